eng_uc_tx: RTL
==============

Name: eng_uc_tx

Overview:
- Engine-side transmit port for unit clauses (UCs) discovered by one BCP engine.
- Queues the engine's unit literals and answers the UC arbiter's round-robin poll, delivering one literal per grant on the eng2uca interface.
- Suppresses duplicate literals by tracking literals the arbiter has already broadcast or this port has already queued.
- One instance per engine, between the engine core and the UC arbiter.

Parameters:
- UC_LENGTH, 1024, number of variables; the literal is {polarity, index}, LIT_W = $clog2(UC_LENGTH)+1 bits.
- DEPTH, 8, transmit FIFO entries (power of 2, at least 2).
- NUM_ENGINE, 4, width of the arbiter engine mask.
- ENG_ID, 0, this engine's bit position in engmask.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  flush the FIFO and seen-map between problems
- eng_uc_valid  in  1  engine presents a new unit literal
- eng_uc_lit  in  LIT_W  unit literal; MSB is polarity
- eng_uc_ready  out  1  FIFO not full (registered)
- engmask  in  NUM_ENGINE  arbiter grant mask; this port uses bit ENG_ID
- eng2uca_valid  out  1  literal offered this cycle
- eng2uca_empty  out  1  nothing to offer while granted
- eng2uca  out  LIT_W  offered literal
- bcast_valid  in  1  arbiter queue broadcasts a literal to engines
- bcast_lit  in  LIT_W  broadcast literal
- overflow  out  1  sticky: a literal was dropped because the FIFO was full
- dup_cnt  out  16  saturating count of dropped duplicate literals

Behaviour:
- Reset (rst=1 at a rising edge): FIFO empty, seen-map all 0, state IDLE, overflow=0, dup_cnt=0, eng_uc_ready=1, eng2uca_valid=0, eng2uca_empty=1, eng2uca=0.
- clear behaves identically to reset, except that it holds one cycle of priority over any same-cycle enqueue, broadcast or pop; all of those are discarded.
- Seen-map:
  - 2*UC_LENGTH bits, indexed by the full literal.
  - Set on bcast_valid at bcast_lit.
  - Set on an accepted enqueue at eng_uc_lit.
  - Exact-literal only; the complement is not checked, because conflict detection belongs to the arbiter.
- Enqueue, evaluated when eng_uc_valid=1, in priority order:
  1. If seen[eng_uc_lit]=1, or bcast_valid=1 with bcast_lit==eng_uc_lit: drop and increment dup_cnt (saturates at 0xFFFF).
  2. Else if the FIFO is full and no pop occurs this cycle: drop and set overflow; the seen bit is not set.
  3. Else: write to the tail and set the seen bit.
  - Enqueue and pop in the same cycle on a full FIFO is accepted; the count is unchanged.
- Grant g = engmask[ENG_ID].
  - The arbiter holds a grant for at least 2 consecutive cycles: it samples eng2uca in the first cycle and updates the mask later.
  - The port offers exactly one literal per contiguous high period of g.
- FSM states IDLE, OFFER, HOLD:
  - IDLE: outputs valid=0, empty=1. When g=1, go to OFFER.
  - OFFER is the first grant cycle; the outputs are combinational from g and the FIFO state, with zero-cycle latency.
    - FIFO non-empty: eng2uca_valid=1, eng2uca_empty=0, eng2uca=head; pop at the clock edge.
    - FIFO empty: valid=0, empty=1, eng2uca=0.
    - A literal enqueued in this same cycle is not visible.
    - Next state: HOLD if g=1, else IDLE.
  - HOLD: outputs valid=0, empty=1, no pop. When g=0, go to IDLE.
  - NUM_ENGINE=1 (mask toggles 1,0,1): each rising edge of g gives a new OFFER.
- eng_uc_ready = (count != DEPTH), registered; deassertion is visible the cycle after the FIFO fills.
- Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.
- Reset or clear while in OFFER: the pop is cancelled and the state returns to IDLE.

Decomposition:
- Package uc_pkg holds:
  - UC_LENGTH and LIT_W constants.
  - uc_lit_t, a struct with pol and idx fields.
  - eng_uc_tx_state_t, an enum with IDLE=2'b00, OFFER=2'b01, HOLD=2'b10.
- Sub-module uc_tx_fifo: a synchronous FIFO with push, pop, flush, head, count, full and empty. Its tail write and head read have no bypass, so an empty FIFO never forwards the pushed literal in the same cycle. It is reusable by the arbiter's uc_queue.
- The seen-map and FSM live in eng_uc_tx.

Test Plan:
- Basic offer: enqueue literals 0x005 and then 0x405 (the same variable with opposite polarity; both are accepted); raise g for 2 cycles, twice. The first grant gives eng2uca=0x005 with valid=1 in its first cycle only; the second grant gives 0x405; a third grant gives empty=1.
- Duplicate suppression:
  - bcast 0x010, then enqueue 0x010: dropped, dup_cnt=1.
  - Enqueue 0x011 twice: the second is dropped, dup_cnt=2.
  - Enqueue 0x012 in the same cycle as bcast 0x012: dropped, dup_cnt=3.
- Full FIFO (DEPTH=8):
  - Enqueue 9 distinct literals with no grant: eng_uc_ready=0 after the 8th, the 9th is dropped, overflow=1, and the seen bit for the 9th stays 0.
  - Re-enqueueing the 9th after a grant frees a slot is accepted.
- Full FIFO with simultaneous pop: enqueue at count=8 in the OFFER cycle. The head is popped, the new literal is accepted, and the count stays 8.
- Grant held 5 cycles: only one pop, and valid=1 only in cycle 1. With NUM_ENGINE=1 and the mask toggling, each rising edge pops one entry.
- Clear or reset mid-operation: assert clear in an OFFER cycle with 3 entries queued. Afterwards the FIFO is empty, the popped entry is not lost to dup_cnt, overflow=0, and the seen-map is clear (previously queued literals are accepted again). Repeat with rst and expect the same result.

Source files
------------

// File: rtl/uc_pkg.sv
// uc_pkg: shared unit-clause constants, literal struct and transmit-port state encoding
package uc_pkg;
    localparam int UC_LENGTH = 1024;
    localparam int LIT_W = $clog2(UC_LENGTH) + 1;
    typedef struct packed {
        logic             pol;
        logic [LIT_W-2:0] idx;
    } uc_lit_t;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OFFER = 2'b01,
        HOLD  = 2'b10
    } eng_uc_tx_state_t;
endpackage

// File: rtl/uc_tx_fifo.sv
// uc_tx_fifo: synchronous FIFO of unit literals; no write-to-read bypass
// Ports: clk/rst, flush (sync clear), push/din (tail write), pop (head advance),
//        head (current head entry), count/full/empty (occupancy status)
module uc_tx_fifo #(
    parameter int W = 11,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    // A push on a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = flush ? '0 : wr_q + AW'(do_push);
        rd_d = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
    assign head = mem_q[rd_q];
    assign count = cnt_q;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/eng_uc_tx.sv
// eng_uc_tx: engine-side unit-clause transmit port with duplicate suppression
// Ports: clk/rst, clear (flush between problems); eng_uc_valid/eng_uc_lit/eng_uc_ready
//        (engine enqueue side); engmask (arbiter grant), eng2uca_valid/eng2uca_empty/eng2uca
//        (offer to arbiter); bcast_valid/bcast_lit (arbiter broadcast); overflow, dup_cnt (status)
module eng_uc_tx #(
    parameter int UC_LENGTH = uc_pkg::UC_LENGTH,
    parameter int DEPTH = 8,
    parameter int NUM_ENGINE = 4,
    parameter int ENG_ID = 0,
    localparam int LW = $clog2(UC_LENGTH) + 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  eng_uc_valid,
    input  logic [LW-1:0]         eng_uc_lit,
    output logic                  eng_uc_ready,
    input  logic [NUM_ENGINE-1:0] engmask,
    output logic                  eng2uca_valid,
    output logic                  eng2uca_empty,
    output logic [LW-1:0]         eng2uca,
    input  logic                  bcast_valid,
    input  logic [LW-1:0]         bcast_lit,
    output logic                  overflow,
    output logic [15:0]           dup_cnt
);
    import uc_pkg::*;
    eng_uc_tx_state_t state_q, state_d, cur;
    logic [2*UC_LENGTH-1:0] seen_q, seen_d;
    logic ovf_q, ovf_d, rdy_q, rdy_d;
    logic [15:0] dup_q, dup_d;
    logic g, offer, pop, dup, accept;
    logic [LW-1:0] head;
    logic [CW-1:0] count;
    logic full, empty;
    uc_tx_fifo #(.W(LW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (accept),
        .pop   (pop),
        .din   (eng_uc_lit),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // The register only ever rests in IDLE or HOLD; the first grant cycle is
    // recognised combinationally as OFFER so the arbiter sees the head with no latency.
    always_comb begin
        g = engmask[ENG_ID];
        cur = (state_q == IDLE && g) ? OFFER : state_q;
        offer = cur == OFFER && !empty;
        pop = offer && !clear;
        eng2uca_valid = offer;
        eng2uca_empty = !offer;
        eng2uca = offer ? head : '0;
        dup = seen_q[eng_uc_lit] || (bcast_valid && bcast_lit == eng_uc_lit);
        accept = eng_uc_valid && !dup && (!full || pop) && !clear;
        state_d = (clear || cur == IDLE || !g) ? IDLE : HOLD;
        seen_d = seen_q;
        if (bcast_valid) seen_d[bcast_lit] = 1'b1;
        if (accept) seen_d[eng_uc_lit] = 1'b1;
        if (clear) seen_d = '0;
        ovf_d = !clear && (ovf_q || (eng_uc_valid && !dup && full && !pop));
        dup_d = clear ? '0 : dup_q + 16'(eng_uc_valid && dup && dup_q != 16'hffff);
        rdy_d = clear || (count + CW'(accept) - CW'(pop)) != CW'(DEPTH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seen_q <= '0;
            ovf_q <= 1'b0;
            dup_q <= '0;
            rdy_q <= 1'b1;
        end else begin
            state_q <= state_d;
            seen_q <= seen_d;
            ovf_q <= ovf_d;
            dup_q <= dup_d;
            rdy_q <= rdy_d;
        end
    end
    assign eng_uc_ready = rdy_q;
    assign overflow = ovf_q;
    assign dup_cnt = dup_q;
endmodule
